// File: rtl/ether_tx_arbiter_pkg.sv
// ether_tx_arbiter_pkg: shared widths, status bit positions and FSM state type
// for the Ethernet TX buffer arbiter and its round-robin picker.
package ether_tx_arbiter_pkg;
    localparam int DATA_W     = 32;
    localparam int LEN_W      = 16;
    localparam int SPACE_W    = 10;
    localparam int MAX_REQ    = 4;
    localparam int IDX_W      = 2;
    localparam int ST_TIMEOUT = 4;
    localparam int ST_STRAY   = 5;
    localparam int ST_FULL    = 6;
    localparam int ST_LAST    = 8;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_GRANT} state_e;
endpackage

// File: rtl/ether_tx_arbiter_rr_pick.sv
// ether_tx_arbiter_rr_pick: combinational round-robin finder; returns the first
// set request strictly after the pointer, wrapping around.
//   req_i   [NREQ]  request vector
//   ptr_i   [IDX_W] index served last
//   found_o         any request set
//   idx_o   [IDX_W] chosen index
module ether_tx_arbiter_rr_pick
    import ether_tx_arbiter_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);
    logic [MAX_REQ-1:0] req_p;
    logic [IDX_W-1:0]   k;

    // Scan from the farthest position back to the nearest so the nearest hit wins.
    always_comb begin
        req_p   = MAX_REQ'(req_i);
        found_o = 1'b0;
        idx_o   = '0;
        k       = '0;
        for (int i = NREQ; i >= 1; i--) begin
            k = IDX_W'((int'(ptr_i) + i) % NREQ);
            if (req_p[k]) begin
                found_o = 1'b1;
                idx_o   = k;
            end
        end
    end
endmodule

// File: rtl/ether_tx_arbiter.sv
// ether_tx_arbiter: shares the MAC TX buffer write port among NREQ frame
// generators, granting round-robin once the buffer can hold the whole frame.
//   clk_i, rst_ni                      clock, async active-low reset
//   req_i / req_length_i               level request and frame length (bytes)
//   req_we_i / req_start_i / req_end_i / req_data_i   per-port word stream
//   gnt_o                              registered one-hot grant
//   tx_we_o / tx_start_o / tx_end_o / tx_data_o       registered TX buffer write
//   tx_ready_i / tx_space_i / tx_full_i               TX buffer state
//   status_o                           grant, sticky error flags, last index
module ether_tx_arbiter
    import ether_tx_arbiter_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*LEN_W-1:0]    req_length_i,
    input  logic [NREQ-1:0]          req_we_i,
    input  logic [NREQ-1:0]          req_start_i,
    input  logic [NREQ-1:0]          req_end_i,
    input  logic [NREQ*DATA_W-1:0]   req_data_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic                     tx_we_o,
    output logic                     tx_start_o,
    output logic                     tx_end_o,
    output logic [DATA_W-1:0]        tx_data_o,
    input  logic                     tx_ready_i,
    input  logic [SPACE_W-1:0]       tx_space_i,
    input  logic                     tx_full_i,
    output logic [15:0]              status_o
);
    state_e              state_q, state_d;
    logic [IDX_W-1:0]    cand_q, cand_d, ptr_q, ptr_d, last_q, last_d, pick_idx;
    logic                pick_found;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                tx_we_q, tx_we_d, tx_start_q, tx_start_d, tx_end_q, tx_end_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                to_q, to_d, stray_q, stray_d, full_q, full_d;
    logic                wr;

    // Pad per-port vectors to MAX_REQ so the 2-bit candidate index is always in range.
    logic [MAX_REQ-1:0]        req_p, we_p, start_p, end_p;
    logic [MAX_REQ*LEN_W-1:0]  len_p;
    logic [MAX_REQ*DATA_W-1:0] data_p;
    logic [LEN_W-1:0]          len_a  [MAX_REQ];
    logic [DATA_W-1:0]         data_a [MAX_REQ];

    assign req_p   = MAX_REQ'(req_i);
    assign we_p    = MAX_REQ'(req_we_i);
    assign start_p = MAX_REQ'(req_start_i);
    assign end_p   = MAX_REQ'(req_end_i);
    assign len_p   = (MAX_REQ*LEN_W)'(req_length_i);
    assign data_p  = (MAX_REQ*DATA_W)'(req_data_i);

    always_comb begin
        for (int i = 0; i < MAX_REQ; i++) begin
            len_a[i]  = len_p[i*LEN_W +: LEN_W];
            data_a[i] = data_p[i*DATA_W +: DATA_W];
        end
    end

    ether_tx_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign wr = we_p[cand_q];

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        ptr_d      = ptr_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        cnt_d      = '0;
        tx_we_d    = 1'b0;
        tx_start_d = 1'b0;
        tx_end_d   = 1'b0;
        tx_data_d  = '0;
        to_d       = to_q;
        stray_d    = stray_q | |(req_we_i & ~gnt_q);
        full_d     = full_q | (tx_we_q & tx_full_i);
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    cand_d  = pick_idx;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!req_p[cand_q]) begin
                    state_d = S_IDLE;
                end else if (tx_ready_i && {4'd0, tx_space_i, 2'd0} > len_a[cand_q]) begin
                    gnt_d   = NREQ'(1) << cand_q;
                    last_d  = cand_q;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                tx_we_d    = wr;
                tx_start_d = wr & start_p[cand_q];
                tx_end_d   = wr & end_p[cand_q];
                tx_data_d  = wr ? data_a[cand_q] : '0;
                cnt_d      = wr ? 16'd0 : cnt_q + 16'd1;
                if (wr && end_p[cand_q]) begin
                    gnt_d   = '0;
                    ptr_d   = cand_q;
                    state_d = S_IDLE;
                end else if (!req_p[cand_q] || (!wr && cnt_q == 16'(TIMEOUT - 1))) begin
                    // Abandoned frame: close it with an empty END word.
                    tx_we_d    = 1'b1;
                    tx_start_d = 1'b0;
                    tx_end_d   = 1'b1;
                    tx_data_d  = '0;
                    gnt_d      = '0;
                    to_d       = 1'b1;
                    ptr_d      = cand_q;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cand_q     <= '0;
            ptr_q      <= IDX_W'(NREQ - 1);
            last_q     <= '0;
            gnt_q      <= '0;
            cnt_q      <= '0;
            tx_we_q    <= 1'b0;
            tx_start_q <= 1'b0;
            tx_end_q   <= 1'b0;
            tx_data_q  <= '0;
            to_q       <= 1'b0;
            stray_q    <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            ptr_q      <= ptr_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            tx_we_q    <= tx_we_d;
            tx_start_q <= tx_start_d;
            tx_end_q   <= tx_end_d;
            tx_data_q  <= tx_data_d;
            to_q       <= to_d;
            stray_q    <= stray_d;
            full_q     <= full_d;
        end
    end

    assign gnt_o      = gnt_q;
    assign tx_we_o    = tx_we_q;
    assign tx_start_o = tx_start_q;
    assign tx_end_o   = tx_end_q;
    assign tx_data_o  = tx_data_q;

    always_comb begin
        status_o                       = '0;
        status_o[3:0]                  = 4'(gnt_q);
        status_o[ST_TIMEOUT]           = to_q;
        status_o[ST_STRAY]             = stray_q;
        status_o[ST_FULL]              = full_q;
        status_o[ST_LAST +: IDX_W]     = last_q;
    end
endmodule

// File: tb/tb_ether_tx_arbiter.sv
// tb_ether_tx_arbiter: directed scenarios plus randomized generators checked
// cycle by cycle against a behavioural model of the arbitration rules.
module tb_ether_tx_arbiter;
    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, we, st, en;
    logic [31:0] len_v;
    logic [63:0] data_v;
    logic        tx_ready, tx_full;
    logic [9:0]  tx_space;
    logic [1:0]  gnt_o;
    logic        tx_we_o, tx_start_o, tx_end_o;
    logic [31:0] tx_data_o;
    logic [15:0] status_o;

    int total = 0;
    int bad   = 0;

    // Model state: last served port, pending candidate, grant owner, idle run, sticky flags.
    int m_ptr, m_cand, m_idle, m_last;
    bit m_have, m_granted, m_to, m_stray, m_full, cur_we;

    ether_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .req_length_i (len_v),
        .req_we_i     (we),
        .req_start_i  (st),
        .req_end_i    (en),
        .req_data_i   (data_v),
        .gnt_o        (gnt_o),
        .tx_we_o      (tx_we_o),
        .tx_start_o   (tx_start_o),
        .tx_end_o     (tx_end_o),
        .tx_data_o    (tx_data_o),
        .tx_ready_i   (tx_ready),
        .tx_space_i   (tx_space),
        .tx_full_i    (tx_full),
        .status_o     (status_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clr();
        we = '0;
        st = '0;
        en = '0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        req = '0;
        clr();
        len_v = '0;
        data_v = '0;
        tx_ready = 1'b0;
        tx_space = '0;
        tx_full = 1'b0;
        m_ptr = NREQ - 1;
        m_cand = 0;
        m_idle = 0;
        m_last = 0;
        m_have = 0;
        m_granted = 0;
        m_to = 0;
        m_stray = 0;
        m_full = 0;
        cur_we = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One clock: apply the current inputs to the model, clock the DUT, compare.
    task automatic step();
        bit nw, ns, ne;
        logic [31:0] nd;
        logic [1:0] eg;
        nw = 0;
        ns = 0;
        ne = 0;
        nd = '0;
        for (int i = 0; i < NREQ; i++)
            if (we[i] && !(m_granted && m_cand == i)) m_stray = 1;
        if (cur_we && tx_full) m_full = 1;
        if (m_granted) begin
            if (we[m_cand]) begin
                nw = 1;
                ns = st[m_cand];
                ne = en[m_cand];
                nd = data_v[m_cand*32 +: 32];
                m_idle = 0;
            end else begin
                m_idle++;
            end
            if (nw && ne) begin
                m_granted = 0;
                m_have = 0;
                m_ptr = m_cand;
            end else if (!req[m_cand] || m_idle == TIMEOUT) begin
                nw = 1;
                ns = 0;
                ne = 1;
                nd = '0;
                m_to = 1;
                m_granted = 0;
                m_have = 0;
                m_ptr = m_cand;
            end
        end else if (m_have) begin
            if (!req[m_cand]) m_have = 0;
            else if (tx_ready && 32'(tx_space) * 4 > 32'(len_v[m_cand*16 +: 16])) begin
                m_granted = 1;
                m_idle = 0;
                m_last = m_cand;
            end
        end else if (|req) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (!m_have && req[(m_ptr + k) % NREQ]) begin
                    m_cand = (m_ptr + k) % NREQ;
                    m_have = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        eg = m_granted ? 2'(1 << m_cand) : 2'b00;
        chk("gnt", 32'(gnt_o), 32'(eg));
        chk("tx_we", 32'(tx_we_o), 32'(nw));
        if (nw) begin
            chk("tx_start", 32'(tx_start_o), 32'(ns));
            chk("tx_end", 32'(tx_end_o), 32'(ne));
            chk("tx_data", tx_data_o, nd);
        end
        chk("status", 32'(status_o),
            32'({6'd0, 2'(m_last), 1'b0, m_full, m_stray, m_to, 2'b00, eg}));
        cur_we = nw;
    endtask

    task automatic wait_grant();
        int n = 0;
        while (gnt_o == '0 && n < 50) begin
            step();
            n++;
        end
        if (gnt_o == '0) chk("gnt_wait", 32'(|gnt_o), 32'd1);
    endtask

    task automatic send_frame(input int p, input int n, input bit drop);
        for (int k = 0; k < n; k++) begin
            we[p] = 1'b1;
            st[p] = (k == 0);
            en[p] = (k == n - 1);
            data_v[p*32 +: 32] = (k == 0) ? {16'd0, len_v[p*16 +: 16]} : $urandom;
            step();
        end
        clr();
        if (drop) req[p] = 1'b0;
    endtask

    int gap[2], nwd[2], sent[2], stall[2], frames[2];
    bit ended[2];
    int g;

    initial begin
        rst_n = 1'b1;
        #2;
        reset_dut();
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_we", 32'(tx_we_o), 32'd0);
        chk("rst_data", tx_data_o, 32'd0);
        chk("rst_status", 32'(status_o), 32'd0);

        // Single requester: grant two cycles after REQ, 17 words forwarded.
        req = 2'b01; len_v[15:0] = 16'd64; tx_space = 10'd20; tx_ready = 1'b1;
        step();
        chk("t1_gnt_early", 32'(gnt_o), 32'd0);
        step();
        chk("t1_gnt", 32'(gnt_o), 32'd1);
        send_frame(0, 17, 1);
        chk("t1_end", 32'(tx_end_o), 32'd1);
        chk("t1_gnt_clr", 32'(gnt_o), 32'd0);

        // Both held: strict alternation starting at port 0.
        reset_dut();
        req = 2'b11; len_v = {16'd8, 16'd8}; tx_space = 10'd20; tx_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            wait_grant();
            g = gnt_o[1] ? 1 : 0;
            chk("t2_order", 32'(g), 32'(r % 2));
            chk("t2_last", 32'(status_o[9:8]), 32'(r % 2));
            send_frame(g, 2, 0);
        end
        req = '0;
        step();

        // Space equal to length is not enough; one more word grants.
        reset_dut();
        req = 2'b01; len_v[15:0] = 16'd80; tx_space = 10'd20; tx_ready = 1'b1;
        repeat (5) step();
        chk("t3_wait", 32'(gnt_o), 32'd0);
        tx_space = 10'd21;
        step();
        chk("t3_gnt", 32'(gnt_o), 32'd1);
        send_frame(0, 3, 1);

        // Stalled generator is closed after TIMEOUT idle cycles; port 1 follows.
        reset_dut();
        req = 2'b11; len_v = {16'd16, 16'd16}; tx_space = 10'd20; tx_ready = 1'b1;
        wait_grant();
        chk("t4_first", 32'(gnt_o), 32'd1);
        for (int k = 0; k < 3; k++) begin
            we[0] = 1'b1; st[0] = (k == 0); data_v[31:0] = 32'h100 + k;
            step();
        end
        clr();
        repeat (TIMEOUT - 1) step();
        chk("t4_no_close", 32'(tx_we_o), 32'd0);
        step();
        chk("t4_close_we", 32'(tx_we_o), 32'd1);
        chk("t4_close_end", 32'(tx_end_o), 32'd1);
        chk("t4_close_data", tx_data_o, 32'd0);
        chk("t4_sticky", 32'(status_o[4]), 32'd1);
        req[0] = 1'b0;
        wait_grant();
        chk("t4_next", 32'(gnt_o), 32'd2);
        send_frame(1, 2, 1);

        // Stray strobes from port 1 do not disturb port 0's stream.
        reset_dut();
        req = 2'b01; len_v[15:0] = 16'd16; tx_space = 10'd20; tx_ready = 1'b1;
        wait_grant();
        for (int k = 0; k < 4; k++) begin
            we[0] = 1'b1; st[0] = (k == 0); en[0] = (k == 3);
            data_v[31:0] = 32'hA000_0000 + k;
            we[1] = (k == 1 || k == 2); data_v[63:32] = 32'hDEAD_BEEF;
            step();
            if (k == 2) chk("t5_data", tx_data_o, 32'hA000_0002);
        end
        clr();
        req = '0;
        chk("t5_stray", 32'(status_o[5]), 32'd1);
        step();

        // Asynchronous reset mid-frame, then normal service of port 1.
        reset_dut();
        req = 2'b01; len_v[15:0] = 16'd16; tx_space = 10'd20; tx_ready = 1'b1;
        wait_grant();
        for (int k = 0; k < 2; k++) begin
            we[0] = 1'b1; st[0] = (k == 0); data_v[31:0] = 32'h55 + k;
            step();
        end
        rst_n = 1'b0;
        #1;
        chk("t6_gnt", 32'(gnt_o), 32'd0);
        chk("t6_we", 32'(tx_we_o), 32'd0);
        chk("t6_data", tx_data_o, 32'd0);
        chk("t6_status", 32'(status_o), 32'd0);
        reset_dut();
        req = 2'b10; len_v[31:16] = 16'd8; tx_space = 10'd20; tx_ready = 1'b1;
        step();
        step();
        chk("t6_regrant", 32'(gnt_o), 32'd2);
        send_frame(1, 2, 1);

        // Randomized generators with gaps, stalls, strays and buffer back-pressure.
        reset_dut();
        for (int i = 0; i < 2; i++) begin
            gap[i] = 0; nwd[i] = 2; sent[i] = 0; stall[i] = 0; frames[i] = 0; ended[i] = 0;
        end
        repeat (3000) begin
            tx_ready = ($urandom_range(0, 3) != 0);
            tx_space = 10'($urandom_range(0, 12));
            tx_full  = ($urandom_range(0, 15) == 0);
            clr();
            for (int i = 0; i < 2; i++) begin
                if (ended[i]) begin
                    req[i] = 1'b0;
                    ended[i] = 0;
                    gap[i] = $urandom_range(0, 4);
                end else if (!req[i]) begin
                    if (gap[i] == 0) begin
                        req[i] = 1'b1;
                        nwd[i] = $urandom_range(2, 6);
                        len_v[i*16 +: 16] = 16'(4 * nwd[i] - $urandom_range(0, 3));
                        sent[i] = 0;
                        stall[i] = 0;
                    end else begin
                        gap[i]--;
                    end
                end else if (gnt_o[i]) begin
                    if (stall[i] >= 6 || $urandom_range(0, 3) != 0) begin
                        we[i] = 1'b1;
                        st[i] = (sent[i] == 0);
                        en[i] = (sent[i] == nwd[i] - 1);
                        data_v[i*32 +: 32] = (sent[i] == 0) ? {16'd0, len_v[i*16 +: 16]} : $urandom;
                        sent[i]++;
                        stall[i] = 0;
                        if (en[i]) begin
                            ended[i] = 1;
                            frames[i]++;
                        end
                    end else begin
                        stall[i]++;
                    end
                end
                if (!gnt_o[i] && $urandom_range(0, 31) == 0) begin
                    we[i] = 1'b1;
                    st[i] = 1'($urandom_range(0, 1));
                    en[i] = 1'($urandom_range(0, 1));
                    data_v[i*32 +: 32] = $urandom;
                end
            end
            step();
        end
        chk("rnd_frames0", 32'(frames[0] >= 40), 32'd1);
        chk("rnd_frames1", 32'(frames[1] >= 40), 32'd1);
        chk("rnd_no_timeout", 32'(status_o[4]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
